// File: rtl/accel_pkg.sv
// Shared constants and helpers for the MAC array datapath blocks.
package accel_pkg;

    localparam int COL     = 8;
    localparam int BW      = 8;
    localparam int BW_PSUM = 2 * BW + 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Lane i of a packed multi-lane bus starts at bit i*w.
    function automatic int lane_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// One column's psum FIFO: circular buffer with occupancy count; head is read combinationally.
module fifo_lane
    import accel_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [bw_psum-1:0] in,
    output logic [bw_psum-1:0] out,
    output logic               empty,
    output logic               full
);

    localparam int AW = clog2(depth);
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(depth);

    logic [bw_psum-1:0] mem_q [depth];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= in;
    end

    assign out   = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_MAX);

endmodule

// File: rtl/ofifo_align.sv
// Output FIFO that re-aligns staggered per-column psum writes into rows popped together.
module ofifo_align
    import accel_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*bw_psum-1:0] in,
    input  logic                   rd,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [col*bw_psum-1:0] out,
    output logic                   out_valid,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    logic [col-1:0]         empty, full, wr_acc;
    logic [col*bw_psum-1:0] head;
    logic                   rd_acc;

    logic [col*bw_psum-1:0] out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;

    // A full lane may still take a write when the shared pop frees a slot in the same edge.
    assign rd_acc = rd & o_valid;
    assign wr_acc = wr & (~full | {col{rd_acc}});

    for (genvar g = 0; g < col; g++) begin : g_lane
        fifo_lane #(
            .bw_psum(bw_psum),
            .depth  (depth)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .wr   (wr_acc[g]),
            .rd   (rd_acc),
            .in   (in[lane_lsb(g, bw_psum) +: bw_psum]),
            .out  (head[lane_lsb(g, bw_psum) +: bw_psum]),
            .empty(empty[g]),
            .full (full[g])
        );
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (rd_acc) begin
            out_d       = head;
            out_valid_d = 1'b1;
        end
        ovf_d = ovf_q | (|(wr & ~wr_acc));
        udf_d = udf_q | (rd & ~o_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

endmodule
